// File: rtl/covox_pkg.sv
// covox_pkg: shared widths, limits and default mix levels for the covox audio back-end.
package covox_pkg;
    localparam int             MIX_W          = 9;
    localparam logic [MIX_W-1:0] MIX_MAX      = 9'd511;
    localparam logic [MIX_W-1:0] PWM_LAST     = 9'd510;
    localparam logic [MIX_W-1:0] BEEP_LEVEL_DEF = 9'd128;
    localparam logic [MIX_W-1:0] TAPE_LEVEL_DEF = 9'd32;
endpackage

// File: rtl/covox_audio_dac_sync2.sv
// sync2: two-flop synchroniser with asynchronous active-low reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, s1} <= 2'b00;
        else        {q, s1} <= {s1, d};
endmodule

// File: rtl/covox_audio_dac.sv
// covox_audio_dac: mixes covox sample, beeper and tapeout into a 1-bit DAC stream.
// COVOX_SIGMA_DELTA_EN selects a first-order sigma-delta modulator; otherwise 9-bit PWM.
module covox_audio_dac
    import covox_pkg::*;
#(
    parameter logic [MIX_W-1:0] BEEP_LEVEL = BEEP_LEVEL_DEF,
    parameter logic [MIX_W-1:0] TAPE_LEVEL = TAPE_LEVEL_DEF
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       covox,
    input  logic [7:0] d,
    input  logic       beeper,
    input  logic       tapeout,
    output logic [7:0] covox_data,
    output logic       audio_out
);
    logic             cv_s2, cv_s3, beep_s, tape_s, armed;
    logic [1:0]       valid;
    logic [MIX_W-1:0] mix;
    logic [MIX_W:0]   mix_sum;

    sync2 u_cv   (.clk(cpu_clock), .rst_n(reset), .d(covox),   .q(cv_s2));
    sync2 u_beep (.clk(cpu_clock), .rst_n(reset), .d(beeper),  .q(beep_s));
    sync2 u_tape (.clk(cpu_clock), .rst_n(reset), .d(tapeout), .q(tape_s));

    assign mix_sum = {2'b00, covox_data} + {1'b0, beep_s ? BEEP_LEVEL : '0}
                   + {1'b0, tape_s ? TAPE_LEVEL : '0};

    // The synchroniser's reset zeros are not real samples: arm capture only once a
    // genuine low has been seen, so a strobe held across reset release is ignored.
    always_ff @(posedge cpu_clock or negedge reset)
        if (!reset) begin
            cv_s3      <= 1'b0;
            valid      <= 2'b00;
            armed      <= 1'b0;
            covox_data <= 8'h00;
            mix        <= '0;
        end else begin
            cv_s3 <= cv_s2;
            valid <= {valid[0], 1'b1};
            armed <= armed | (valid[1] & ~cv_s2);
            if (armed & cv_s2 & ~cv_s3) covox_data <= d;
            mix   <= (mix_sum > {1'b0, MIX_MAX}) ? MIX_MAX : mix_sum[MIX_W-1:0];
        end

`ifdef COVOX_SIGMA_DELTA_EN
    logic [MIX_W-1:0] acc;
    logic [MIX_W:0]   acc_sum;
    assign acc_sum = {1'b0, acc} + {1'b0, mix};
    always_ff @(posedge cpu_clock or negedge reset)
        if (!reset) begin
            acc       <= '0;
            audio_out <= 1'b0;
        end else begin
            acc       <= acc_sum[MIX_W-1:0];
            audio_out <= acc_sum[MIX_W];
        end
`else
    logic [MIX_W-1:0] cnt, duty;
    // Duty reloads only at the period boundary so a period never glitches.
    always_ff @(posedge cpu_clock or negedge reset)
        if (!reset) begin
            cnt       <= '0;
            duty      <= '0;
            audio_out <= 1'b0;
        end else begin
            cnt       <= (cnt == PWM_LAST) ? '0 : cnt + 9'd1;
            if (cnt == PWM_LAST) duty <= mix;
            audio_out <= cnt < duty;
        end
`endif
endmodule

// File: tb/tb_covox_audio_dac.sv
// tb_covox_audio_dac: directed self-checking bench for covox_audio_dac (either modulator build).
module tb_covox_audio_dac;
    logic       cpu_clock = 1'b0;
    logic       reset = 1'b0;
    logic       covox = 1'b0;
    logic [7:0] d = 8'h00;
    logic       beeper = 1'b0;
    logic       tapeout = 1'b0;
    logic [7:0] covox_data;
    logic       audio_out;
    int         n_tests = 0;
    int         n_fail = 0;
    int         c;

`ifdef COVOX_SIGMA_DELTA_EN
    localparam int WIN = 512;
`else
    localparam int WIN = 511;
`endif

    covox_audio_dac dut (
        .cpu_clock(cpu_clock), .reset(reset), .covox(covox), .d(d),
        .beeper(beeper), .tapeout(tapeout), .covox_data(covox_data), .audio_out(audio_out)
    );

    always #5 cpu_clock = ~cpu_clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge cpu_clock);
    endtask

    task automatic write(input logic [7:0] v, input int hi, input int lo);
        covox = 1'b1;
        d = v;
        cyc(hi);
        covox = 1'b0;
        cyc(lo);
    endtask

    task automatic count_ones(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge cpu_clock);
            cnt += int'(audio_out);
        end
    endtask

`ifndef COVOX_SIGMA_DELTA_EN
    task automatic pwm_midperiod;
        logic a [0:1999];
        int   rises[$];
        int   h0, h1;
        write(8'h10, 4, 4);
        cyc(1200);
        for (int t = 0; t < 2000; t++) begin
            @(negedge cpu_clock);
            a[t] = audio_out;
            if (t > 0 && a[t] && !a[t-1]) rises.push_back(t);
            if (rises.size() > 0) begin
                if (t == rises[0] + 100) begin covox = 1'b1; d = 8'h40; end
                if (t == rises[0] + 104) covox = 1'b0;
            end
        end
        check("pwm_data", int'(covox_data), 8'h40);
        check("pwm_rises_found", int'(rises.size() >= 3), 1);
        if (rises.size() >= 3) begin
            h0 = 0;
            h1 = 0;
            for (int t = rises[0]; t < rises[1]; t++) h0 += int'(a[t]);
            for (int t = rises[1]; t < rises[2]; t++) h1 += int'(a[t]);
            check("pwm_old_duty_kept", h0, 16);
            check("pwm_new_duty", h1, 64);
            check("pwm_period0", rises[1] - rises[0], 511);
            check("pwm_period1", rises[2] - rises[1], 511);
        end
    endtask
`endif

    initial begin
        covox = 1'b1;
        d = 8'hFF;
        cyc(5);
        check("reset_data", int'(covox_data), 0);
        check("reset_audio", int'(audio_out), 0);
        reset = 1'b1;
        cyc(10);
        check("release_high_no_capture", int'(covox_data), 0);
        covox = 1'b0;
        cyc(5);

        covox = 1'b1;
        d = 8'hA5;
        cyc(2);
        check("write_lat2", int'(covox_data), 0);
        cyc(1);
        check("write_lat3", int'(covox_data), 8'hA5);
        d = 8'h5A;
        cyc(1);
        covox = 1'b0;
        cyc(6);
        check("single_capture", int'(covox_data), 8'hA5);

        covox = 1'b1;
        d = 8'h10;
        cyc(3);
        check("b2b_first", int'(covox_data), 8'h10);
        covox = 1'b0;
        cyc(3);
        covox = 1'b1;
        d = 8'h20;
        cyc(3);
        check("b2b_second", int'(covox_data), 8'h20);
        covox = 1'b0;
        cyc(6);
        check("b2b_final", int'(covox_data), 8'h20);

        write(8'h00, 4, 4);
        beeper = 1'b1;
        cyc(1200);
        count_ones(WIN, c);
        check("beeper_only", c, 128);

        beeper = 1'b0;
        tapeout = 1'b1;
        cyc(1200);
        count_ones(WIN, c);
        check("tape_only", c, 32);

        beeper = 1'b1;
        write(8'hFF, 4, 4);
        cyc(1200);
        count_ones(WIN, c);
        check("full_mix_415", c, 415);

        beeper = 1'b0;
        tapeout = 1'b0;
        write(8'h00, 4, 4);
        cyc(1200);
        count_ones(2048, c);
        check("all_zero", c, 0);

`ifndef COVOX_SIGMA_DELTA_EN
        pwm_midperiod();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
